fir_sym_mc: RTL and testbench
=============================

Name: fir_sym_mc

Overview:
- Multi-channel, time-multiplexed symmetric FIR filter. Next generation of the team's single-channel bit-serial FIR.
- Adds: per-channel sample delay lines sharing one coefficient set; ready/valid handshakes on input and output; correct signed coefficient arithmetic; round-half-up; saturation to the unsigned output range.
- Sits between the sample source (ADC/test pattern) and the DAC/output formatter.

Parameters:
DataWidth, 12, sample width; samples UFix<DataWidth,0>
CoeffWidth, 12, coefficient width; SFix<1,CoeffWidth-1>
NTaps, 9, filter length; must be odd (elaboration $fatal otherwise)
NChannels, 2, number of independent channels (>=1)
NCoeffs (local), (NTaps+1)/2, stored coefficients c[0..NCoeffs-1]
AccWidth (local), DataWidth+CoeffWidth+$clog2(NTaps)+1, signed accumulator width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
coeff_load_en  in  1  serial coefficient load enable
coeff_in  in  1  serial coefficient bit
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_ch  in  max(1,$clog2(NChannels))  channel of the input sample
x  in  DataWidth  input sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_ch  out  max(1,$clog2(NChannels))  channel of the result
y  out  DataWidth  filtered sample
out_sat  out  1  result was clamped

Behaviour:
- Reset (rst=1 at a clk edge) has the following effects:
  - state=IDLE.
  - All delay lines and coefficients are cleared to 0.
  - Accumulator and counters are cleared.
  - out_valid=0, y=0, out_ch=0, out_sat=0.
  - in_ready=0 during the reset cycle.
  - Reset mid-MAC or mid-OUT aborts the operation; no output is produced.
- States: IDLE, LOAD, MAC, OUT.
- in_ready = (state==IDLE) && !coeff_load_en. Coefficient load takes priority over a simultaneous in_valid.
- IDLE:
  - coeff_load_en=1 -> LOAD.
  - Otherwise in_valid && in_ready (acceptance edge) -> MAC.
  - On acceptance, x is shifted into delay line d[in_ch] (d[in_ch][0]=x, older taps move up one; d[in_ch][NTaps-1] is dropped) and in_ch is latched.
  - in_ch >= NChannels: the handshake completes, the sample is discarded, there is no output, and the state stays IDLE.
- LOAD:
  - Each cycle with coeff_load_en=1 shifts coeff_in into the bit-chain.
  - NCoeffs*CoeffWidth bits form one full load. The first bit is the MSB of c[NCoeffs-1]; the last bit is the LSB of c[0].
  - coeff_load_en=0 -> IDLE. A partial load leaves a partially shifted chain, with no error.
  - coeff_load_en is ignored in MAC and OUT.
- MAC: pair counter p = 0..NCoeffs-1, bit counter b = 0..DataWidth.
  - Pre-sum s_p = d[ch][p] + d[ch][NTaps-1-p], DataWidth+1 bits unsigned. For p = NCoeffs-1, s_p = d[ch][NTaps/2] only.
  - Each cycle: if s_p[b]=1, acc += sign_extend(c[p]) << b.
  - b wraps at DataWidth, then p increments.
  - The accumulator clears on the acceptance edge.
  - The MAC state lasts exactly NCoeffs*(DataWidth+1) cycles (65 at defaults).
- OUT:
  - Entered on the edge after the last MAC cycle, so out_valid is first high NCoeffs*(DataWidth+1)+1 edges after acceptance (66 at defaults).
  - r = (acc + 2^(CoeffWidth-2)) >>> (CoeffWidth-1), arithmetic shift (round half up).
  - y = clamp(r, 0, 2^DataWidth-1); out_sat=1 iff clamped.
  - y, out_ch and out_sat are registered and stable while out_valid=1.
  - out_valid && out_ready -> IDLE, and out_valid drops next cycle. in_ready stays 0 throughout OUT.
- Channels are fully independent. A sample on one channel never affects another channel's delay line.

Test Plan:
- Impulse, default parameters: load c[4]=0x400, others 0. Feed ch0 samples 1000,0,0,0,0, out_ready=1. Expect y = 0,0,0,0,500, out_sat=0, out_valid exactly 66 edges after each acceptance.
- Rounding: c[4]=0x001, others 0. After the target sample reaches tap 4, x=1024 -> y=1; x=1023 -> y=0.
- Saturation:
  - All c=0x7FF; feed 4095 nine times -> final y=4095, out_sat=1.
  - All c=0 except c[0]=0x800; feed 4095 -> y=0, out_sat=1.
- Channels and bad channel: c[4]=0x400. Interleave ch0 = 2000 and ch1 = 400, five each. Expect the fifth outputs to be 1000 on out_ch=0 and 200 on out_ch=1. A sample with in_ch=2 gives no out_valid and leaves both lines unchanged.
- Backpressure and priority:
  - Hold out_ready=0 for 10 cycles after out_valid: y, out_ch, out_sat stay stable and in_ready=0.
  - In IDLE with in_valid=1 and coeff_load_en=1 simultaneously: in_ready=0 and the load proceeds.
- Reset mid-MAC: assert rst 20 cycles after acceptance. Expect no out_valid, all delay lines read 0, and the next impulse reproduces the first scenario.

Source files
------------

// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric FIR filter: one shared coefficient set and a delay line per channel.
// A bit-serial MAC walks the pre-summed tap pairs, then the result is rounded and saturated.
module fir_sym_mc #(
   parameter int DataWidth  = 12,
   parameter int CoeffWidth = 12,
   parameter int NTaps      = 9,
   parameter int NChannels  = 2,
   localparam int ChWidth   = (NChannels > 1) ? $clog2(NChannels) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 coeff_load_en,
   input  logic                 coeff_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ChWidth-1:0]   in_ch,
   input  logic [DataWidth-1:0] x,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ChWidth-1:0]   out_ch,
   output logic [DataWidth-1:0] y,
   output logic                 out_sat
);

   localparam int NCoeffs    = (NTaps + 1) / 2;
   localparam int AccWidth   = DataWidth + CoeffWidth + $clog2(NTaps) + 1;
   localparam int ChainWidth = NCoeffs * CoeffWidth;
   localparam int PW         = (NCoeffs > 1) ? $clog2(NCoeffs) : 1;
   localparam int BW         = $clog2(DataWidth + 1);

   localparam logic signed [AccWidth-1:0] RoundBias = AccWidth'(1) << (CoeffWidth - 2);
   localparam logic signed [AccWidth-1:0] YMax      = (AccWidth'(1) << DataWidth) - AccWidth'(1);

   if (NTaps % 2 == 0) begin : g_taps_odd
      $fatal(1, "fir_sym_mc: NTaps must be odd");
   end

   typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

   state_t                      state;
   logic [DataWidth-1:0]        d [NChannels][NTaps];
   logic [ChainWidth-1:0]       coeff_chain;
   logic [ChWidth-1:0]          ch;
   logic [PW-1:0]               p;
   logic [BW-1:0]               b;
   logic signed [AccWidth-1:0]  acc;
   logic [DataWidth:0]          pre_sum;
   logic [CoeffWidth-1:0]       coeff;
   logic signed [AccWidth-1:0]  coeff_term;
   logic signed [AccWidth-1:0]  acc_rnd;
   logic signed [AccWidth-1:0]  rounded;
   logic                        ch_ok;

   assign in_ready = (state == IDLE) && !coeff_load_en && !rst;
   assign ch_ok    = int'(in_ch) < NChannels;

   // Pair p folds taps p and NTaps-1-p; the centre tap stands alone.
   always_comb begin
      pre_sum = '0;
      coeff   = '0;
      for (int unsigned k = 0; k < NCoeffs; k++) begin
         if (PW'(k) == p) begin
            coeff = coeff_chain[k*CoeffWidth +: CoeffWidth];
            if (k == NCoeffs - 1)
               pre_sum = {1'b0, d[ch][k]};
            else
               pre_sum = {1'b0, d[ch][k]} + {1'b0, d[ch][NTaps-1-k]};
         end
      end
   end

   assign coeff_term = {{(AccWidth-CoeffWidth){coeff[CoeffWidth-1]}}, coeff} << b;
   assign acc_rnd    = acc + RoundBias;
   assign rounded    = acc_rnd >>> (CoeffWidth - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         coeff_chain <= '0;
         ch          <= '0;
         p           <= '0;
         b           <= '0;
         acc         <= '0;
         out_valid   <= 1'b0;
         out_ch      <= '0;
         y           <= '0;
         out_sat     <= 1'b0;
         for (int unsigned c = 0; c < NChannels; c++)
            for (int unsigned k = 0; k < NTaps; k++)
               d[c][k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (coeff_load_en) begin
                  state <= LOAD;
               end else if (in_valid && ch_ok) begin
                  for (int unsigned c = 0; c < NChannels; c++) begin
                     if (ChWidth'(c) == in_ch) begin
                        d[c][0] <= x;
                        for (int unsigned k = 1; k < NTaps; k++)
                           d[c][k] <= d[c][k-1];
                     end
                  end
                  ch    <= in_ch;
                  acc   <= '0;
                  p     <= '0;
                  b     <= '0;
                  state <= MAC;
               end
            end
            LOAD: begin
               if (coeff_load_en)
                  coeff_chain <= {coeff_chain[ChainWidth-2:0], coeff_in};
               else
                  state <= IDLE;
            end
            MAC: begin
               if (pre_sum[b])
                  acc <= acc + coeff_term;
               if (b == BW'(DataWidth)) begin
                  b <= '0;
                  if (p == PW'(NCoeffs - 1))
                     state <= OUT;
                  else
                     p <= p + 1'b1;
               end else begin
                  b <= b + 1'b1;
               end
            end
            OUT: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_ch    <= ch;
                  if (rounded[AccWidth-1]) begin
                     y       <= '0;
                     out_sat <= 1'b1;
                  end else if (rounded > YMax) begin
                     y       <= '1;
                     out_sat <= 1'b1;
                  end else begin
                     y       <= rounded[DataWidth-1:0];
                     out_sat <= 1'b0;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_sym_mc.sv
// Self-checking bench for fir_sym_mc: directed scenarios plus randomized traffic
// compared against a direct-form convolution model. Three channels so an invalid code exists.
module tb_fir_sym_mc;

   localparam int DW  = 12;
   localparam int CW  = 12;
   localparam int NT  = 9;
   localparam int NCH = 3;
   localparam int NC  = (NT + 1) / 2;

   logic          clk = 1'b0;
   logic          rst, coeff_load_en, coeff_in, in_valid, in_ready;
   logic          out_valid, out_ready, out_sat;
   logic [1:0]    in_ch, out_ch;
   logic [DW-1:0] x, y;

   int checks = 0;
   int errors = 0;
   int mcoef [NC];
   int hist  [NCH][NT];
   int last_y, last_ch, last_sat;

   fir_sym_mc #(.DataWidth(DW), .CoeffWidth(CW), .NTaps(NT), .NChannels(NCH)) dut (
      .clk(clk), .rst(rst), .coeff_load_en(coeff_load_en), .coeff_in(coeff_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .x(x),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .y(y), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Full-length convolution with mirrored coefficients, then round half up and clamp.
   function automatic void model_eval(input int chv, output int ey, output int es);
      longint acc, r;
      acc = 0;
      for (int k = 0; k < NT; k++)
         acc += longint'(hist[chv][k]) * longint'(mcoef[(k < NC) ? k : NT - 1 - k]);
      r = (acc + 1024) >>> 11;
      if (r < 0) begin ey = 0; es = 1; end
      else if (r > 4095) begin ey = 4095; es = 1; end
      else begin ey = int'(r); es = 0; end
   endfunction

   task automatic clear_model();
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < NT; k++) hist[c][k] = 0;
      for (int i = 0; i < NC; i++) mcoef[i] = 0;
   endtask

   task automatic random_coeffs();
      for (int i = 0; i < NC; i++) mcoef[i] = int'($urandom_range(0, 4095)) - 2048;
   endtask

   task automatic load_coeffs(input bit with_valid);
      logic [CW-1:0] bits;
      coeff_load_en = 1'b1; coeff_in = 1'b0;
      in_valid = with_valid; in_ch = 2'd0; x = 12'd77;
      #1;
      if (with_valid) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL load_priority in_ready got %b want 0", in_ready);
         end
      end
      @(posedge clk); #1;
      for (int i = NC - 1; i >= 0; i--) begin
         bits = CW'(mcoef[i]);
         for (int j = CW - 1; j >= 0; j--) begin
            coeff_in = bits[j];
            @(posedge clk); #1;
         end
      end
      coeff_load_en = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic push(input int chv, input int xv, input int hold);
      int lat, ey, es;
      logic [DW-1:0] y0;
      logic [1:0] c0;
      logic s0;
      bit quiet;
      in_valid = 1'b1; in_ch = 2'(chv); x = DW'(xv);
      #1;
      lat = 0;
      while (in_ready !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL accept_ready got %b want 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (chv >= NCH) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bad_ch_idle in_ready got %b want 1", in_ready);
         end
         quiet = 1;
         for (int i = 0; i < 80; i++) begin
            if (out_valid !== 1'b0) quiet = 0;
            @(posedge clk); #1;
         end
         checks++;
         if (!quiet) begin errors++; $display("FAIL bad_ch_no_output out_valid got 1 want 0"); end
         return;
      end
      for (int k = NT - 1; k > 0; k--) hist[chv][k] = hist[chv][k-1];
      hist[chv][0] = xv;
      model_eval(chv, ey, es);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", in_ready); end
      out_ready = (hold == 0);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (out_valid !== 1'b1 && lat < 200);
      checks++;
      if (lat != 66) begin errors++; $display("FAIL latency got %0d want 66", lat); end
      checks++;
      if (y !== DW'(ey)) begin errors++; $display("FAIL y ch%0d got %0d want %0d", chv, y, ey); end
      checks++;
      if (out_ch !== 2'(chv)) begin errors++; $display("FAIL out_ch got %0d want %0d", out_ch, chv); end
      checks++;
      if (out_sat !== 1'(es)) begin errors++; $display("FAIL out_sat got %b want %0d", out_sat, es); end
      last_y = int'(y); last_ch = int'(out_ch); last_sat = int'(out_sat);
      if (hold > 0) begin
         y0 = y; c0 = out_ch; s0 = out_sat;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || y !== y0 || out_ch !== c0 || out_sat !== s0 || in_ready !== 1'b0) begin
               errors++;
               $display("FAIL hold_stable cyc%0d got v=%b y=%0d ch=%0d sat=%b rdy=%b want v=1 y=%0d ch=%0d sat=%b rdy=0",
                        i, out_valid, y, out_ch, out_sat, in_ready, y0, c0, s0);
            end
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; coeff_load_en = 1'b0; coeff_in = 1'b0; in_valid = 1'b0;
      in_ch = 2'd0; x = '0; out_ready = 1'b1;
      clear_model();
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++;
      if (y !== '0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
      checks++;
      if (out_ch !== 2'd0 || out_sat !== 1'b0) begin
         errors++; $display("FAIL reset_ch_sat got ch=%0d sat=%b want 0 0", out_ch, out_sat);
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", in_ready); end
   endtask

   task automatic impulse_check(input string tag);
      for (int i = 0; i < NC; i++) mcoef[i] = 0;
      mcoef[4] = 1024;
      load_coeffs(0);
      push(0, 1000, 0);
      for (int i = 0; i < 4; i++) push(0, 0, 0);
      checks++;
      if (last_y != 500 || last_sat != 0) begin
         errors++; $display("FAIL %s got y=%0d sat=%0d want y=500 sat=0", tag, last_y, last_sat);
      end
   endtask

   task automatic test_impulse();
      impulse_check("impulse");
   endtask

   task automatic test_rounding();
      for (int i = 0; i < NC; i++) mcoef[i] = 0;
      mcoef[4] = 1;
      load_coeffs(0);
      push(0, 1024, 0);
      for (int i = 0; i < 4; i++) push(0, 0, 0);
      checks++;
      if (last_y != 1) begin errors++; $display("FAIL round_up got %0d want 1", last_y); end
      push(0, 1023, 0);
      for (int i = 0; i < 4; i++) push(0, 0, 0);
      checks++;
      if (last_y != 0) begin errors++; $display("FAIL round_down got %0d want 0", last_y); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < NC; i++) mcoef[i] = 2047;
      load_coeffs(0);
      for (int i = 0; i < NT; i++) push(0, 4095, 0);
      checks++;
      if (last_y != 4095 || last_sat != 1) begin
         errors++; $display("FAIL sat_high got y=%0d sat=%0d want 4095 1", last_y, last_sat);
      end
      for (int i = 0; i < NC; i++) mcoef[i] = 0;
      mcoef[0] = -2048;
      load_coeffs(0);
      push(0, 4095, 0);
      checks++;
      if (last_y != 0 || last_sat != 1) begin
         errors++; $display("FAIL sat_low got y=%0d sat=%0d want 0 1", last_y, last_sat);
      end
   endtask

   task automatic test_channels();
      for (int i = 0; i < NC; i++) mcoef[i] = 0;
      mcoef[4] = 1024;
      load_coeffs(0);
      for (int i = 0; i < 5; i++) begin
         push(0, 2000, 0);
         if (i == 4) begin
            checks++;
            if (last_y != 1000 || last_ch != 0) begin
               errors++; $display("FAIL chan0 got y=%0d ch=%0d want 1000 0", last_y, last_ch);
            end
         end
         push(1, 400, 0);
         if (i == 4) begin
            checks++;
            if (last_y != 200 || last_ch != 1) begin
               errors++; $display("FAIL chan1 got y=%0d ch=%0d want 200 1", last_y, last_ch);
            end
         end
      end
      push(3, 4000, 0);
      push(0, 2000, 0);
      push(1, 400, 0);
   endtask

   task automatic test_backpressure();
      random_coeffs();
      load_coeffs(0);
      push(1, int'($urandom_range(0, 4095)), 10);
      push(2, int'($urandom_range(0, 4095)), 10);
   endtask

   task automatic test_priority();
      random_coeffs();
      load_coeffs(1);
      for (int i = 0; i < 4; i++) push(2, int'($urandom_range(0, 4095)), 0);
   endtask

   task automatic test_random();
      random_coeffs();
      load_coeffs(0);
      for (int i = 0; i < 24; i++)
         push(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)));
   endtask

   task automatic test_reset_mid_mac();
      bit quiet;
      random_coeffs();
      load_coeffs(0);
      for (int c = 0; c < NCH; c++) push(c, int'($urandom_range(1, 4095)), 0);
      in_valid = 1'b1; in_ch = 2'd1; x = 12'd3000;
      #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL midmac_reset_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_model();
      quiet = 1;
      for (int i = 0; i < 100; i++) begin
         if (out_valid !== 1'b0) quiet = 0;
         @(posedge clk); #1;
      end
      checks++;
      if (!quiet) begin errors++; $display("FAIL midmac_no_output out_valid got 1 want 0"); end
      random_coeffs();
      load_coeffs(0);
      for (int c = 0; c < NCH; c++) push(c, int'($urandom_range(1, 4095)), 0);
      impulse_check("post_reset_impulse");
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_rounding();
      test_saturation();
      test_channels();
      test_backpressure();
      test_priority();
      test_random();
      test_reset_mid_mac();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
